// File: rtl/binarysearch_datapath_if.sv
// binarysearch_datapath_if: strobe, RAM and result bundle between the search controller side and the datapath.
interface binarysearch_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] A_in;
    logic              load_A;
    logic              set_L;
    logic              set_R;
    logic              set_M;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              F;
    logic              NF;
    logic [ADDR_W-1:0] loc;
    logic [ADDR_W:0]   probes;
    modport master (
        output A_in, load_A, set_L, set_R, set_M, mem_rdata,
        input  mem_addr, F, NF, loc, probes
    );
    modport slave (
        input  A_in, load_A, set_L, set_R, set_M, mem_rdata,
        output mem_addr, F, NF, loc, probes
    );
endinterface

// File: rtl/binarysearch_datapath.sv
// binarysearch_datapath: target/bounds/midpoint registers and 3-cycle probe sequencer for a sorted sync-read RAM.
// Define BSEARCH_PROBE_CNT_EN to enable the saturating compare counter on probes (tied to 0 otherwise).
module binarysearch_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input logic                    clock,
    input logic                    reset,
    binarysearch_datapath_if.slave bus
);
    typedef enum logic [1:0] {P_ISSUE, P_WAIT, P_CMP} phase_t;
    localparam logic [ADDR_W-1:0] R_INIT = ADDR_W'(DEPTH - 1);
    phase_t            state, nstate;
    logic [DATA_W-1:0] a;
    logic [ADDR_W-1:0] l, r, m, loc_q;
    logic              f, nf, adv, do_issue, do_cmp;
    logic [ADDR_W:0]   sum;
    assign adv = bus.set_M & ~bus.load_A & ~f & ~nf;
    assign sum = {1'b0, l} + {1'b0, r};
    always_ff @(posedge clock)
        if (reset) state <= P_ISSUE;
        else state <= nstate;
    always_comb
        nstate = bus.load_A ? P_ISSUE :
                 !adv ? state :
                 state == P_ISSUE ? P_WAIT :
                 state == P_WAIT ? P_CMP : P_ISSUE;
    always_comb begin
        do_issue = adv & (state == P_ISSUE);
        do_cmp   = adv & (state == P_CMP);
    end
    // boundary tests come first so L/R never step outside [0, DEPTH-1]
    always_ff @(posedge clock) begin
        if (reset) begin
            a <= '0;
            l <= '0;
            r <= R_INIT;
            m <= '0;
            f <= 1'b0;
            nf <= 1'b0;
            loc_q <= '0;
        end else if (bus.load_A) begin
            a <= bus.A_in;
            l <= '0;
            r <= R_INIT;
            f <= 1'b0;
            nf <= 1'b0;
            loc_q <= '0;
        end else begin
            if (do_issue) m <= sum[ADDR_W:1];
            if (do_cmp) begin
                if (bus.mem_rdata == a) begin
                    f <= 1'b1;
                    loc_q <= m;
                end else if (bus.mem_rdata < a) begin
                    if (m == r) nf <= 1'b1;
                    else if (bus.set_L) l <= m + 1'b1;
                end else begin
                    if (m == l) nf <= 1'b1;
                    else if (bus.set_R) r <= m - 1'b1;
                end
            end
        end
    end
`ifdef BSEARCH_PROBE_CNT_EN
    logic [ADDR_W:0] cnt;
    always_ff @(posedge clock)
        if (reset || bus.load_A) cnt <= '0;
        else if (do_cmp && cnt != '1) cnt <= cnt + 1'b1;
    assign bus.probes = cnt;
`else
    assign bus.probes = '0;
`endif
    assign bus.mem_addr = m;
    assign bus.F        = f;
    assign bus.NF       = nf;
    assign bus.loc      = loc_q;
endmodule
